// File: rtl/xdma_pkg.sv
// Shared definitions for the xdma RAM <-> external-bus DMA initiator:
// register indices, CTRL/STATUS bit positions and FSM state encoding.
package xdma_pkg;

  localparam logic [2:0] REG_INT_ADDR = 3'd0;
  localparam logic [2:0] REG_EXT_ADDR = 3'd1;
  localparam logic [2:0] REG_LEN      = 3'd2;
  localparam logic [2:0] REG_CTRL     = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  localparam int CTRL_START    = 0;
  localparam int CTRL_DIR      = 1;
  localparam int CTRL_IRQ_MASK = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_RD_INT   = 3'd2,
    S_WAIT_INT = 3'd3,
    S_EXT_WR   = 3'd4,
    S_EXT_RD   = 3'd5,
    S_WR_INT   = 3'd6,
    S_NEXT     = 3'd7
  } state_t;

endpackage

// File: rtl/xdma.sv
// DMA initiator moving LEN words between the shared RAM data port and an external req/ack bus.
// Optional build macro XDMA_IRQ_EN adds the irq output and the CTRL bit2 interrupt mask.
module xdma
  import xdma_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter int DATA_W = 32,
  parameter int EXT_AW = 32,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_sel,
  input  logic              ctrl_we,
  input  logic [2:0]        ctrl_addr,
  input  logic [DATA_W-1:0] ctrl_data_in,
  output logic [DATA_W-1:0] ctrl_data_out,
  input  logic              mem_busy,
  output logic              dma_sel,
  output logic              dma_we,
  output logic [MEM_AW-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_data_in,
  input  logic [DATA_W-1:0] dma_data_out,
  output logic              ext_req,
  output logic              ext_we,
  output logic [EXT_AW-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ack
`ifdef XDMA_IRQ_EN
  ,
  output logic              irq
`endif
);

  state_t              r_state;
  state_t              w_next;
  logic [MEM_AW-1:0]   r_int_addr;
  logic [EXT_AW-1:0]   r_ext_addr;
  logic [LEN_W-1:0]    r_len;
  logic                r_dir;
  logic                r_done;
  logic [DATA_W-1:0]   r_buf;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_busy;
  logic                w_wr;
  logic                w_rd;
  logic                w_start;
  logic                w_last;
  logic                w_unused;

  assign w_busy   = (r_state != S_IDLE);
  assign w_wr     = ctrl_sel & ctrl_we;
  assign w_rd     = ctrl_sel & ~ctrl_we;
  assign w_start  = w_wr && (ctrl_addr == REG_CTRL) && ctrl_data_in[CTRL_START] && !w_busy;
  assign w_last   = (r_state == S_NEXT) && (r_len == LEN_W'(1));
  assign w_unused = ^ctrl_data_in;

  // The single data buffer carries the word toward whichever side is written next.
  assign dma_addr      = r_int_addr;
  assign dma_data_in   = r_buf;
  assign ext_addr      = r_ext_addr;
  assign ext_wdata     = r_buf;
  assign ctrl_data_out = r_rdata;

`ifdef XDMA_IRQ_EN
  logic r_mask;
  assign irq = r_done & r_mask;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    dma_sel = 1'b0;
    dma_we  = 1'b0;
    ext_req = 1'b0;
    ext_we  = 1'b0;
    case (r_state)
      S_IDLE:     if (w_start && (r_len != '0)) w_next = S_START;
      S_START:    w_next = r_dir ? S_RD_INT : S_EXT_RD;
      S_RD_INT: begin
        dma_sel = 1'b1;
        if (!mem_busy) w_next = S_WAIT_INT;
      end
      S_WAIT_INT: w_next = S_EXT_WR;
      S_EXT_WR: begin
        ext_req = 1'b1;
        ext_we  = 1'b1;
        if (ext_ack) w_next = S_NEXT;
      end
      S_EXT_RD: begin
        ext_req = 1'b1;
        if (ext_ack) w_next = S_WR_INT;
      end
      S_WR_INT: begin
        dma_sel = 1'b1;
        dma_we  = 1'b1;
        if (!mem_busy) w_next = S_NEXT;
      end
      S_NEXT:     w_next = w_last ? S_IDLE : (r_dir ? S_RD_INT : S_EXT_RD);
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (ctrl_addr)
      REG_INT_ADDR: w_rdata = DATA_W'(r_int_addr);
      REG_EXT_ADDR: w_rdata = DATA_W'(r_ext_addr);
      REG_LEN:      w_rdata = DATA_W'(r_len);
      REG_CTRL: begin
        w_rdata[CTRL_DIR] = r_dir;
`ifdef XDMA_IRQ_EN
        w_rdata[CTRL_IRQ_MASK] = r_mask;
`endif
      end
      REG_STATUS: begin
        w_rdata[STAT_BUSY] = w_busy;
        w_rdata[STAT_DONE] = r_done;
      end
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_addr <= '0;
      r_ext_addr <= '0;
      r_len      <= '0;
      r_dir      <= 1'b0;
      r_done     <= 1'b0;
      r_buf      <= '0;
      r_rdata    <= '0;
`ifdef XDMA_IRQ_EN
      r_mask     <= 1'b0;
`endif
    end else begin
      if (w_wr && !w_busy) begin
        case (ctrl_addr)
          REG_INT_ADDR: r_int_addr <= ctrl_data_in[MEM_AW-1:0];
          REG_EXT_ADDR: r_ext_addr <= ctrl_data_in[EXT_AW-1:0];
          REG_LEN:      r_len      <= ctrl_data_in[LEN_W-1:0];
          REG_CTRL:     r_dir      <= ctrl_data_in[CTRL_DIR];
          default:      ;
        endcase
      end
`ifdef XDMA_IRQ_EN
      if (w_wr && (ctrl_addr == REG_CTRL)) r_mask <= ctrl_data_in[CTRL_IRQ_MASK];
`endif
      if (r_state == S_WAIT_INT)            r_buf <= dma_data_out;
      if ((r_state == S_EXT_RD) && ext_ack) r_buf <= ext_rdata;
      if (r_state == S_NEXT) begin
        r_int_addr <= r_int_addr + MEM_AW'(1);
        r_ext_addr <= r_ext_addr + EXT_AW'(1);
        r_len      <= r_len - LEN_W'(1);
      end
      // Completion outranks a same-cycle STATUS write so a finish is never lost.
      if ((w_start && (r_len == '0)) || w_last)     r_done <= 1'b1;
      else if (w_wr && (ctrl_addr == REG_STATUS))   r_done <= 1'b0;
      if (w_rd) r_rdata <= w_rdata;
    end
  end

endmodule

// File: tb/tb_xdma.sv
// Randomized self-checking bench for xdma: RAM and external-bus responders plus a
// transfer-level reference model (expected access queues built when START is issued).
module tb_xdma;
  localparam int MEM_AW = 12;
  localparam int DATA_W = 32;
  localparam int EXT_AW = 32;
  localparam int LEN_W  = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_sel, ctrl_we;
  logic [2:0]  ctrl_addr;
  logic [31:0] ctrl_data_in, ctrl_data_out;
  logic        mem_busy;
  logic        dma_sel, dma_we;
  logic [11:0] dma_addr;
  logic [31:0] dma_data_in, dma_data_out;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_ack;
`ifdef XDMA_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  xdma #(.MEM_AW(MEM_AW), .DATA_W(DATA_W), .EXT_AW(EXT_AW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .ctrl_sel(ctrl_sel), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr),
    .ctrl_data_in(ctrl_data_in), .ctrl_data_out(ctrl_data_out),
    .mem_busy(mem_busy), .dma_sel(dma_sel), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_data_in(dma_data_in), .dma_data_out(dma_data_out),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack)
`ifdef XDMA_IRQ_EN
    , .irq(irq)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext_fn(input logic [31:0] e);
    return {e[15:0], ~e[15:0]};
  endfunction

  // environment state
  logic [31:0] ram [0:4095];
  int          busy_rate = 0;
  int          busy_until = 0;
  int          cyc = 0;
  bit          spurious = 0;
  int          ack_seq[$];

  // reference model
  logic [11:0] m_int;
  logic [31:0] m_ext;
  logic [11:0] m_len;
  logic        m_dir, m_mask, m_done, m_busy;
  logic [11:0] q_rd[$];
  logic [43:0] q_ramw[$];
  logic [63:0] q_extw[$];
  logic [31:0] q_extrd[$];
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  int          stall_cnt = 0;

  task automatic model_reset();
    m_int = '0; m_ext = '0; m_len = '0; m_dir = 0; m_mask = 0; m_done = 0; m_busy = 0;
    q_rd.delete(); q_ramw.delete(); q_extw.delete(); q_extrd.delete();
  endtask

  task automatic model_start();
    logic [11:0] a;
    logic [31:0] e;
    if (m_len == 0) begin
      m_done = 1;
      return;
    end
    m_busy = 1;
    for (int i = 0; i < int'(m_len); i++) begin
      a = m_int + 12'(i);
      e = m_ext + 32'(i);
      if (m_dir) begin
        q_rd.push_back(a);
        q_extw.push_back({e, ram[a]});
      end else begin
        q_extrd.push_back(e);
        q_ramw.push_back({a, ext_fn(e)});
      end
    end
    m_int = m_int + m_len;
    m_ext = m_ext + 32'(m_len);
    m_len = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    ctrl_sel = 1; ctrl_we = 1; ctrl_addr = a; ctrl_data_in = d;
    @(posedge clk); #1;
    ctrl_sel = 0; ctrl_we = 0;
`ifdef XDMA_IRQ_EN
    if (a == 3) m_mask = d[2];
`endif
    if (a == 4) m_done = 0;
    if (!m_busy) begin
      case (a)
        3'd0: m_int = d[11:0];
        3'd1: m_ext = d;
        3'd2: m_len = d[11:0];
        3'd3: begin m_dir = d[1]; if (d[0]) model_start(); end
        default: ;
      endcase
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    ctrl_sel = 1; ctrl_we = 0; ctrl_addr = a;
    @(posedge clk); #1;
    ctrl_sel = 0;
    v = ctrl_data_out;
  endtask

  task automatic wait_done();
    logic [31:0] v;
    for (int i = 0; i < 3000; i++) begin
      rd(3'd4, v);
      if (!v[0]) break;
    end
    if (m_busy) begin m_busy = 0; m_done = 1; end
    chk("status_end", v, {30'd0, m_done, 1'b0});
  endtask

  task automatic check_regs();
    logic [31:0] v;
    rd(3'd0, v); chk("reg_int_addr", v, {20'd0, m_int});
    rd(3'd1, v); chk("reg_ext_addr", v, m_ext);
    rd(3'd2, v); chk("reg_len", v, {20'd0, m_len});
    rd(3'd3, v); chk("reg_ctrl", v, {29'd0, m_mask, m_dir, 1'b0});
    chk("queues_drained", q_rd.size() + q_ramw.size() + q_extw.size() + q_extrd.size(), 0);
  endtask

  // RAM port and external bus responders
  initial begin
    logic        rd_pend = 0;
    logic [11:0] rd_addr = '0;
    bit          in_req = 0;
    int          wait_cnt = 0, cur_delay = 0;
    mem_busy = 0; ext_ack = 0; ext_rdata = 0; dma_data_out = 0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        in_req = 0; rd_pend = 0;
      end else begin
        if (dma_sel && !mem_busy) begin
          if (dma_we) ram[dma_addr] = dma_data_in;
          else begin rd_pend = 1; rd_addr = dma_addr; end
        end
        if (ext_req) begin
          if (!in_req) begin
            in_req = 1; wait_cnt = 0;
            cur_delay = (ack_seq.size() != 0) ? ack_seq.pop_front() : int'($urandom_range(0, 3));
          end
          if (wait_cnt == cur_delay) begin
            ext_ack = 1;
            if (!ext_we) ext_rdata = ext_fn(ext_addr);
            in_req = 0;
          end else wait_cnt++;
        end else begin
          in_req = 0;
          if (spurious && $urandom_range(0, 3) == 0) ext_ack = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
      ext_ack = 0;
      ext_rdata = $urandom;
      dma_data_out = rd_pend ? ram[rd_addr] : $urandom;
      rd_pend = 0;
      mem_busy = (cyc < busy_until) || ($urandom_range(0, 99) < busy_rate);
    end
  end

  // per-cycle compare against the model's expected access streams
  initial begin
    bit          pv = 0;
    logic        p_req = 0, p_ack = 0, p_we = 0;
    logic [31:0] p_addr = 0, p_wdata = 0;
    logic [63:0] e64;
    logic [43:0] e44;
    forever begin
      @(negedge clk); #2;
      if (rst) pv = 0;
      else begin
        chk("ram_ext_exclusive", {63'd0, dma_sel & ext_req}, 0);
        if (pv && p_req && !p_ack) begin
          chk("ext_req_held", {ext_req, ext_we, ext_addr}, {1'b1, p_we, p_addr});
          if (p_we) chk("ext_wdata_held", ext_wdata, p_wdata);
        end
        if (dma_sel && mem_busy) stall_cnt++;
        if (dma_sel && !mem_busy && !dma_we) begin
          chk("ram_rd_expected", q_rd.size() != 0, 1);
          if (q_rd.size() != 0) chk("ram_rd_addr", dma_addr, q_rd.pop_front());
        end
        if (dma_sel && !mem_busy && dma_we) begin
          chk("ram_wr_expected", q_ramw.size() != 0, 1);
          if (q_ramw.size() != 0) begin
            e44 = q_ramw.pop_front();
            chk("ram_wr_addr_data", {dma_addr, dma_data_in}, e44);
          end
        end
        if (ext_req && ext_ack && ext_we) begin
          log_a.push_back(ext_addr); log_d.push_back(ext_wdata);
          chk("ext_wr_expected", q_extw.size() != 0, 1);
          if (q_extw.size() != 0) begin
            e64 = q_extw.pop_front();
            chk("ext_wr_addr_data", {ext_addr, ext_wdata}, e64);
          end
        end
        if (ext_req && ext_ack && !ext_we) begin
          chk("ext_rd_expected", q_extrd.size() != 0, 1);
          if (q_extrd.size() != 0) chk("ext_rd_addr", ext_addr, q_extrd.pop_front());
        end
        pv = 1; p_req = ext_req; p_ack = ext_ack; p_we = ext_we; p_addr = ext_addr; p_wdata = ext_wdata;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          s0;
    rst = 1; ctrl_sel = 0; ctrl_we = 0; ctrl_addr = 0; ctrl_data_in = 0;
    for (int i = 0; i < 4096; i++) ram[i] = $urandom;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl_outs", {dma_sel, dma_we, ext_req, ext_we}, 0);
    chk("rst_dma_addr", dma_addr, 0);
    chk("rst_dma_wdata", dma_data_in, 0);
    chk("rst_ext_addr", ext_addr, 0);
    chk("rst_ext_wdata", ext_wdata, 0);
    chk("rst_ctrl_out", ctrl_data_out, 0);
    rst = 0;
    rd(3'd4, v); chk("rst_status", v, 0);

    // RAM -> ext, LEN=4
    for (int i = 0; i < 4; i++) ram[12'h10 + i] = 32'hA000_0000 + i;
    log_a.delete(); log_d.delete();
    wr(3'd0, 32'h10); wr(3'd1, 32'h100); wr(3'd2, 4); wr(3'd3, 3);
    wait_done();
    chk("t1_nwrites", log_a.size(), 4);
    if (log_a.size() == 4) begin
      chk("t1_addr0", log_a[0], 32'h100);
      chk("t1_addr3", log_a[3], 32'h103);
      chk("t1_data0", log_d[0], 32'hA000_0000);
      chk("t1_data3", log_d[3], 32'hA000_0003);
    end
    rd(3'd0, v); chk("t1_int_after", v, 32'h14);
    check_regs();

    // ext -> RAM, ack delays 0/2/5
    ack_seq = '{0, 2, 5};
    wr(3'd0, 32'h20); wr(3'd1, 32'h200); wr(3'd2, 3); wr(3'd3, 1);
    wait_done();
    chk("t2_ram20", ram[12'h20], 32'h0200_FDFF);
    chk("t2_ram22", ram[12'h22], 32'h0202_FDFD);
    check_regs();

    // mem_busy held while the first RAM read is pending
    wr(3'd0, 32'h30); wr(3'd1, 32'h300); wr(3'd2, 2);
    s0 = stall_cnt;
    busy_until = cyc + 7;
    wr(3'd3, 3);
    wait_done();
    chk("t3_stalled_3plus", (stall_cnt - s0) >= 3, 1);
    check_regs();

    // LEN=0 start
    wr(3'd4, 0); rd(3'd4, v); chk("t4_done_cleared", v, 0);
    wr(3'd2, 0); wr(3'd3, 3);
    rd(3'd4, v); chk("t4_len0_done", v, 32'h2);
    check_regs();

    // internal address wrap
    log_a.delete(); log_d.delete();
    wr(3'd0, 32'hFFF); wr(3'd1, 32'h50); wr(3'd2, 2); wr(3'd3, 3);
    wait_done();
    rd(3'd0, v); chk("t5_int_wrapped", v, 32'h001);
    if (log_d.size() == 2) chk("t5_word_from_0", log_d[1], ram[0]);
    check_regs();

    // START and register writes while busy are ignored
    ack_seq = '{5, 5, 5};
    wr(3'd0, 32'h40); wr(3'd1, 32'h400); wr(3'd2, 3); wr(3'd3, 1);
    wr(3'd2, 7); wr(3'd3, 1); wr(3'd0, 32'h999);
    wait_done();
    rd(3'd2, v); chk("t6_len_zero", v, 0);
    check_regs();

    // done-clear write landing on the completion edge
    ack_seq = '{0};
    wr(3'd4, 0); wr(3'd0, 32'h60); wr(3'd1, 32'h600); wr(3'd2, 1); wr(3'd3, 1);
    repeat (3) @(posedge clk);
    #1;
    wr(3'd4, 0);
    wait_done();
    check_regs();

`ifdef XDMA_IRQ_EN
    wr(3'd4, 0); wr(3'd3, 32'h4);
    chk("irq_idle", irq, 0);
    wr(3'd2, 1); wr(3'd3, 32'h7);
    wait_done();
    chk("irq_set", irq, 1);
    wr(3'd4, 0);
    chk("irq_cleared", irq, 0);
`else
    wr(3'd3, 32'h6);
`endif
    check_regs();

    // reset while an external write waits for ack
    ack_seq = '{20};
    wr(3'd0, 32'h70); wr(3'd1, 32'h700); wr(3'd2, 2); wr(3'd3, 3);
    for (int i = 0; i < 50; i++) begin
      if (ext_req) break;
      @(posedge clk); #1;
    end
    chk("t8_ext_req_seen", ext_req, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    chk("t8_req_dropped", {ext_req, dma_sel}, 0);
    rd(3'd4, v); chk("t8_status", v, 0);
    check_regs();

    // randomized transfers
    busy_rate = 30; spurious = 1;
    for (int t = 0; t < 25; t++) begin
      wr(3'd0, $urandom); wr(3'd1, $urandom);
      wr(3'd2, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) wr(3'd4, 0);
      wr(3'd3, {29'd0, 1'($urandom), 1'($urandom), 1'b1});
      wait_done();
      check_regs();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
